uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `uart_tx` serializer between `NUM_REQUESTERS` byte-stream sources. Grants are held for a whole packet, delimited by `req_last` or by a `MAX_BURST` beat cap, so bytes from different sources never interleave inside a packet. It sits directly in front of `uart_tx`: `out_*` connects to its `data_valid`/`data_ready`/`data_bits`.

---
 rtl/uart_pkg.sv | 16 +
 rtl/rr_priority_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 122 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmit arbiter
package uart_pkg;

  // IDLE arbitrates, TAG emits the source-id header byte, STREAM passes a packet through
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TAG    = 2'd1,
    STREAM = 2'd2
  } arb_state_t;

  // Width of a source id (and therefore of the tag payload) for n sources
  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - round-robin pick of the first request after the last winner
module rr_priority_pick
  import uart_pkg::*;
#(
  parameter int N = 4,
  localparam int W = tag_width(N)
) (
  input  logic [N-1:0] request,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] index
);

  logic [W-1:0] cand;

  // Scan N positions starting one past the last winner; the first hit wins
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = W'((int'(last) + k) % N);
      if (!found && request[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter in front of uart_tx (option: UART_TX_ARBITER_TAG_EN)
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int NUMBER_OF_BITS = 8,
  parameter int MAX_BURST      = 16
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [NUM_REQUESTERS-1:0]                     req_valid,
  output logic [NUM_REQUESTERS-1:0]                     req_ready,
  input  logic [NUM_REQUESTERS-1:0][NUMBER_OF_BITS-1:0] req_data,
  input  logic [NUM_REQUESTERS-1:0]                     req_last,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [NUMBER_OF_BITS-1:0]                     out_data,
  output logic [$clog2(NUM_REQUESTERS)-1:0]             grant_id,
  output logic                                          busy
);

  localparam int IDW = $clog2(NUM_REQUESTERS);
  localparam int BCW = $clog2(MAX_BURST);

`ifdef UART_TX_ARBITER_TAG_EN
  if (NUMBER_OF_BITS < tag_width(NUM_REQUESTERS)) begin : g_tag_fits
    $error("uart_tx_arbiter: NUMBER_OF_BITS cannot hold the grant tag");
  end
`endif

  arb_state_t     state, state_next;
  logic [IDW-1:0] last_grant, last_grant_next;
  logic [IDW-1:0] grant_next;
  logic [BCW-1:0] beat_count, beat_count_next;
  logic           pick_found;
  logic [IDW-1:0] pick_index;
  logic           stream_beat;

  rr_priority_pick #(
    .N(NUM_REQUESTERS)
  ) u_pick (
    .request(req_valid),
    .last   (last_grant),
    .found  (pick_found),
    .index  (pick_index)
  );

  // State and grant bookkeeping registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IDW'(NUM_REQUESTERS - 1);
      grant_id   <= '0;
      beat_count <= '0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      grant_id   <= grant_next;
      beat_count <= beat_count_next;
    end
  end

  // Next-state decision and the output muxes for the granted source
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    grant_next      = grant_id;
    beat_count_next = beat_count;
    out_valid       = 1'b0;
    out_data        = '0;
    req_ready       = '0;
    busy            = 1'b0;
    stream_beat     = 1'b0;

    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_next      = pick_index;
          beat_count_next = '0;
`ifdef UART_TX_ARBITER_TAG_EN
          state_next      = TAG;
`else
          state_next      = STREAM;
`endif
        end
      end

`ifdef UART_TX_ARBITER_TAG_EN
      TAG: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = NUMBER_OF_BITS'(grant_id);
        if (out_ready) begin
          state_next = STREAM;
        end
      end
`endif

      STREAM: begin
        busy                = 1'b1;
        out_valid           = req_valid[grant_id];
        out_data            = req_data[grant_id];
        req_ready[grant_id] = out_ready;
        stream_beat         = req_valid[grant_id] && out_ready;
        if (stream_beat) begin
          // The closing beat leaves the count alone so it can never wrap
          if (req_last[grant_id] || (beat_count == BCW'(MAX_BURST - 1))) begin
            state_next      = IDLE;
            last_grant_next = grant_id;
          end else begin
            beat_count_next = beat_count + 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXB = 4;
  localparam int IDW  = $clog2(N);
`ifdef UART_TX_ARBITER_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic                clock = 1'b0;
  logic                reset;
  logic [N-1:0]        rv;
  logic [N-1:0]        rr;
  logic [N-1:0][W-1:0] rd;
  logic [N-1:0]        rl;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        out_data;
  logic [IDW-1:0]      grant_id;
  logic                busy;

  always #5 clock = ~clock;

  uart_tx_arbiter #(
    .NUM_REQUESTERS(N),
    .NUMBER_OF_BITS(W),
    .MAX_BURST     (MAXB)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(rv),
    .req_ready(rr),
    .req_data (rd),
    .req_last (rl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .grant_id (grant_id),
    .busy     (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Source-side packet queues and the log of bytes accepted by uart_tx
  logic [7:0] q_data [N][$];
  bit         q_last [N][$];
  bit         pause  [N];
  int         n_popped [N];
  logic [7:0] out_log [$];
  logic [7:0] exp_q [$];

  // Reference model: 0 = waiting for requests, 1 = header byte, 2 = passing a packet
  int m_phase, m_g, m_cnt, m_last;

  typedef struct packed {
    logic [N-1:0]   rv;
    logic [W-1:0]   d;
    logic           l;
    logic           ordy;
    logic           e_ov;
    logic [W-1:0]   e_od;
    logic [N-1:0]   e_rr;
    logic           e_busy;
    logic [IDW-1:0] e_gid;
  } vec_t;
  vec_t tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_last  = N - 1;
    m_g     = 0;
    m_cnt   = 0;
  endtask

  task automatic model_check();
    logic [N-1:0] e_rr;
    logic         e_ov;
    logic [W-1:0] e_od;
    e_rr = '0;
    e_ov = 1'b0;
    e_od = '0;
    if (m_phase == 1) begin
      e_ov = 1'b1;
      e_od = W'(m_g);
    end else if (m_phase == 2) begin
      e_ov       = rv[m_g];
      e_od       = rd[m_g];
      e_rr[m_g]  = out_ready;
    end
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("out_valid", 32'(out_valid), 32'(e_ov));
    check("out_data", 32'(out_data), 32'(e_od));
    check("req_ready", 32'(rr), 32'(e_rr));
    check("grant_id", 32'(grant_id), 32'(m_g));
  endtask

  task automatic model_update();
    bit hit;
    int idx;
    if (reset) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (rv != '0) begin
        hit = 1'b0;
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (!hit && rv[idx]) begin
            hit = 1'b1;
            m_g = idx;
          end
        end
        m_cnt   = 0;
        m_phase = TAG_EN ? 1 : 2;
      end
    end else if (m_phase == 1) begin
      if (out_ready) m_phase = 2;
    end else if (rv[m_g] && out_ready) begin
      m_cnt++;
      if (rl[m_g] || m_cnt == MAXB) begin
        m_phase = 0;
        m_last  = m_g;
      end
    end
  endtask

  // One clock: present queue heads, check against the model, then advance both
  task automatic step();
    for (int i = 0; i < N; i++) begin
      rv[i] = (q_data[i].size() != 0) && !pause[i];
      rd[i] = rv[i] ? q_data[i][0] : 8'h00;
      rl[i] = rv[i] ? q_last[i][0] : 1'b0;
    end
    #1;
    model_check();
    if (out_valid && out_ready) out_log.push_back(out_data);
    for (int i = 0; i < N; i++) begin
      if (rv[i] && rr[i]) begin
        void'(q_data[i].pop_front());
        void'(q_last[i].pop_front());
        n_popped[i]++;
      end
    end
    model_update();
    @(negedge clock);
  endtask

  task automatic load(input int src, input logic [7:0] first, input int len);
    for (int b = 0; b < len; b++) begin
      q_data[src].push_back(8'(int'(first) + b));
      q_last[src].push_back(b == len - 1);
    end
  endtask

  task automatic load_rand(input int src);
    int len;
    len = $urandom_range(1, 6);
    for (int b = 0; b < len; b++) begin
      q_data[src].push_back(8'($urandom));
      q_last[src].push_back(b == len - 1);
    end
  endtask

  task automatic expect_bytes(input int src, input logic [7:0] first, input int len);
    if (TAG_EN) exp_q.push_back(8'(src));
    for (int b = 0; b < len; b++) exp_q.push_back(8'(int'(first) + b));
  endtask

  task automatic drain(input string name, input int budget);
    int  c;
    bit  pending;
    c = 0;
    pending = 1'b1;
    while (pending && c < budget) begin
      pending = (m_phase != 0);
      for (int i = 0; i < N; i++) if (q_data[i].size() != 0) pending = 1'b1;
      if (pending) begin
        step();
        c++;
      end
    end
    check({name, "_timeout"}, 32'(c < budget), 32'd1);
  endtask

  task automatic check_log(input string name);
    check({name, "_len"}, 32'(out_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_log.size(); i++)
      check($sformatf("%s_byte%0d", name, i), 32'(out_log[i]), 32'(exp_q[i]));
    out_log.delete();
    exp_q.delete();
  endtask

  initial begin
    int c;

    reset     = 1'b1;
    rv        = '0;
    rd        = '0;
    rl        = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      pause[i]    = 1'b0;
      n_popped[i] = 0;
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_ready", 32'(rr), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);

    // Single packet from source 2, cycle by cycle against hand-written expectations
    tbl.push_back('{4'b0100, 8'h41, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0});
`ifdef UART_TX_ARBITER_TAG_EN
    tbl.push_back('{4'b0100, 8'h41, 1'b0, 1'b1, 1'b1, 8'h02, 4'b0000, 1'b1, 2'd2});
`endif
    tbl.push_back('{4'b0100, 8'h41, 1'b0, 1'b1, 1'b1, 8'h41, 4'b0100, 1'b1, 2'd2});
    tbl.push_back('{4'b0100, 8'h42, 1'b0, 1'b1, 1'b1, 8'h42, 4'b0100, 1'b1, 2'd2});
    tbl.push_back('{4'b0100, 8'h43, 1'b1, 1'b1, 1'b1, 8'h43, 4'b0100, 1'b1, 2'd2});
    tbl.push_back('{4'b0000, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2});
    for (int t = 0; t < tbl.size(); t++) begin
      rv        = tbl[t].rv;
      rd        = '0;
      rd[2]     = tbl[t].d;
      rl        = '0;
      rl[2]     = tbl[t].l;
      out_ready = tbl[t].ordy;
      #1;
      check($sformatf("vec%0d_out_valid", t), 32'(out_valid), 32'(tbl[t].e_ov));
      check($sformatf("vec%0d_out_data", t), 32'(out_data), 32'(tbl[t].e_od));
      check($sformatf("vec%0d_req_ready", t), 32'(rr), 32'(tbl[t].e_rr));
      check($sformatf("vec%0d_busy", t), 32'(busy), 32'(tbl[t].e_busy));
      check($sformatf("vec%0d_grant_id", t), 32'(grant_id), 32'(tbl[t].e_gid));
      model_update();
      @(negedge clock);
    end

    // Round-robin: two rounds of src0 and src1 offered together
    load(0, 8'h10, 2);
    load(1, 8'h20, 2);
    expect_bytes(0, 8'h10, 2);
    expect_bytes(1, 8'h20, 2);
    drain("rr1", 100);
    check_log("rr1");
    load(0, 8'h12, 2);
    load(1, 8'h22, 2);
    expect_bytes(0, 8'h12, 2);
    expect_bytes(1, 8'h22, 2);
    drain("rr2", 100);
    check_log("rr2");

    // Burst cap: src0 six bytes, src1 waiting
    load(0, 8'h30, 6);
    load(1, 8'h40, 2);
    expect_bytes(0, 8'h30, 4);
    expect_bytes(1, 8'h40, 2);
    expect_bytes(0, 8'h34, 2);
    drain("burst", 100);
    check_log("burst");

    // Backpressure: out_ready toggles while src3 waits
    load(2, 8'h50, 3);
    load(3, 8'h60, 1);
    expect_bytes(2, 8'h50, 3);
    expect_bytes(3, 8'h60, 1);
    foreach (tbl[t]) begin end
    out_ready = 1'b1; step();
    out_ready = 1'b1; step();
    out_ready = 1'b0; step();
    out_ready = 1'b0; step();
    out_ready = 1'b1; step();
    drain("backpressure", 100);
    check_log("backpressure");

    // Header tag (or plain byte when the tag option is off)
    load(3, 8'h55, 1);
    expect_bytes(3, 8'h55, 1);
    drain("tag", 100);
    check_log("tag");

    // Reset mid-packet: src0 finishes first so last_grant is 0, then src1 is cut off
    load(0, 8'h70, 1);
    expect_bytes(0, 8'h70, 1);
    drain("pre", 100);
    check_log("pre");
    load(1, 8'h80, 5);
    n_popped[1] = 0;
    c = 0;
    while (n_popped[1] < 2 && c < 50) begin
      step();
      c++;
    end
    check("midpkt_timeout", 32'(c < 50), 32'd1);
    expect_bytes(1, 8'h80, 2);
    check_log("midpkt");
    q_data[1].delete();
    q_last[1].delete();
    reset     = 1'b1;
    out_ready = 1'b0;
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_req_ready", 32'(rr), 32'd0);
    check("mrst_grant_id", 32'(grant_id), 32'd0);
    load(0, 8'h90, 1);
    load(1, 8'h80, 5);
    expect_bytes(0, 8'h90, 1);
    expect_bytes(1, 8'h80, 4);
    expect_bytes(1, 8'h84, 1);
    drain("post_reset", 100);
    check_log("post_reset");

    // Random traffic, stalls and backpressure against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (q_data[i].size() == 0 && $urandom_range(0, 7) == 0) load_rand(i);
        pause[i] = ($urandom_range(0, 3) == 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    for (int i = 0; i < N; i++) pause[i] = 1'b0;
    out_ready = 1'b1;
    drain("random", 2000);
    out_log.delete();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
